// File: rtl/ot_sha3_squeeze_ctrl_if.sv
// Client-side bundle of the squeeze controller: command request and digest word stream.
interface ot_sha3_squeeze_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  strength;
  logic [7:0]  out_len;
  logic        msg_done;
  logic        digest_valid;
  logic        digest_ready;
  logic [63:0] digest_data;
  logic        digest_last;

  modport master (
    output cmd_valid, strength, out_len, msg_done, digest_ready,
    input  cmd_ready, digest_valid, digest_data, digest_last
  );

  modport slave (
    input  cmd_valid, strength, out_len, msg_done, digest_ready,
    output cmd_ready, digest_valid, digest_data, digest_last
  );
endinterface

// File: rtl/ot_sha3_squeeze_ctrl.sv
// Sequences the SHA3 core through start/absorb/squeeze and streams the (unmasked)
// Keccak state out as 64-bit words, issuing extra runs for outputs longer than one rate block.
module ot_sha3_squeeze_ctrl #(
  parameter bit  EnMasking = 1'b0,
  localparam int Share     = EnMasking ? 2 : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ot_sha3_squeeze_ctrl_if.slave   bus,
  output logic                    start_o,
  output logic                    process_o,
  output logic                    run_o,
  output logic [3:0]              done_o,
  input  logic [3:0]              absorbed_i,
  input  logic                    squeezing_i,
  input  logic                    state_valid_i,
  input  logic [Share-1:0][1599:0] state_i,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAbsorb,
    StProcess,
    StWaitAbsorb,
    StWaitSqueeze,
    StRead,
    StRun,
    StWaitRun,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_strength;
  logic [4:0]  r_word_idx;
  logic [7:0]  r_remain;
  logic        r_cmd_err;

  logic [4:0]        w_rate;
  logic [1599:0]     w_state_unm;
  logic [31:0][63:0] w_lanes;
  logic              w_accept;
  logic              w_strength_ok;
  logic              w_core_live;
  logic              w_read_err;
  logic              w_hs;

  // Rate block length in 64-bit words for each security strength.
  function automatic logic [4:0] rate_words(input logic [2:0] s);
    case (s)
      3'd0:    rate_words = 5'd21;
      3'd1:    rate_words = 5'd18;
      3'd2:    rate_words = 5'd17;
      3'd3:    rate_words = 5'd13;
      3'd4:    rate_words = 5'd9;
      default: rate_words = 5'd1;
    endcase
  endfunction

  if (EnMasking) begin : g_masked
    assign w_state_unm = state_i[0] ^ state_i[Share-1];
  end else begin : g_unmasked
    assign w_state_unm = state_i[0];
  end

  // Lanes beyond the 25 Keccak lanes read as zero so any 5-bit index is safe.
  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < 25; i++) begin
      w_lanes[i] = w_state_unm[64*i +: 64];
    end
  end

  assign w_rate        = rate_words(r_strength);
  assign w_strength_ok = (bus.strength <= 3'd4);
  assign w_accept      = bus.cmd_valid && (r_state == StIdle);
  assign w_core_live   = squeezing_i && state_valid_i;
  assign w_read_err    = (r_state == StRead) && !w_core_live;
  assign w_hs          = bus.digest_valid && bus.digest_ready;

  always_comb begin
    w_state_nxt      = r_state;
    bus.cmd_ready    = 1'b0;
    bus.digest_valid = 1'b0;
    bus.digest_last  = 1'b0;
    bus.digest_data  = 64'd0;
    start_o          = 1'b0;
    process_o        = 1'b0;
    run_o            = 1'b0;
    done_o           = MuBi4False;
    busy_o           = (r_state != StIdle);
    error_o          = r_cmd_err || w_read_err;

    case (r_state)
      StIdle: begin
        bus.cmd_ready = 1'b1;
        if (w_accept && w_strength_ok) w_state_nxt = StStart;
      end
      StStart: begin
        start_o     = 1'b1;
        w_state_nxt = StAbsorb;
      end
      StAbsorb: begin
        if (bus.msg_done) w_state_nxt = StProcess;
      end
      StProcess: begin
        process_o   = 1'b1;
        w_state_nxt = StWaitAbsorb;
      end
      StWaitAbsorb: begin
        if (absorbed_i == MuBi4True) w_state_nxt = StWaitSqueeze;
      end
      StWaitSqueeze: begin
        if (w_core_live) w_state_nxt = StRead;
      end
      StRead: begin
        // Losing the squeeze state mid-stream aborts via Done so the core gets flushed.
        if (!w_core_live) begin
          w_state_nxt = StDone;
        end else begin
          bus.digest_valid = 1'b1;
          bus.digest_last  = (r_remain == 8'd1);
          bus.digest_data  = w_lanes[r_word_idx];
          if (bus.digest_ready) begin
            if (r_remain == 8'd1)                    w_state_nxt = StDone;
            else if (r_word_idx == w_rate - 5'd1)    w_state_nxt = StRun;
          end
        end
      end
      StRun: begin
        run_o       = 1'b1;
        w_state_nxt = StWaitRun;
      end
      StWaitRun: begin
        if (!squeezing_i) w_state_nxt = StWaitSqueeze;
      end
      StDone: begin
        done_o      = MuBi4True;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_strength <= 3'd0;
      r_word_idx <= 5'd0;
      r_remain   <= 8'd0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_err <= w_accept && !w_strength_ok;
      if (w_accept) begin
        r_strength <= bus.strength;
        r_remain   <= (bus.out_len == 8'd0) ? 8'd1 : bus.out_len;
        r_word_idx <= 5'd0;
      end else if (w_hs) begin
        r_remain   <= r_remain - 8'd1;
        r_word_idx <= (r_word_idx == w_rate - 5'd1) ? 5'd0 : r_word_idx + 5'd1;
      end
    end
  end

endmodule
